vdp_ctl_port: RTL and testbench
===============================

# vdp_ctl_port

Parametrised control/data port engine for the VDP, successor to the mode-0 register write interface. It decodes the two-byte control-port protocol into either a config-register write or a VRAM address setup (read or write mode). It owns the status register with its sticky flags and IRQ, and runs the single-outstanding VRAM access handshake with a read-ahead buffer. Optionally it adds V9938-style indirect register writes with auto-increment. It sits between the Z8S180 bus tick decoder and the VDP render/VRAM arbiter.

## Interface
- REG_AW, 3, register index width; NREGS = 2**REG_AW (legal 3..6)
- VADDR_W, 14, VRAM address width (legal 14..17; >14 requires REG_AW>=4)
- INDIRECT, 0, 1 enables the indirect port via R17 (requires REG_AW==6)

- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low, sampled on rising clk
- ctl_wr_tick  in  1  one-cycle control-port write strobe
- ctl_rd_tick  in  1  one-cycle status read strobe
- dat_wr_tick / dat_rd_tick  in  1  one-cycle VRAM data port strobes
- ind_wr_tick  in  1  one-cycle indirect-port write strobe (ignored if INDIRECT=0)
- din  in  8  CPU write data, valid during any write tick
- status_dout  out  8  {F,5S,C,fifth_num[4:0]}, combinational from registers
- data_dout  out  8  read-ahead buffer, combinational
- regs_flat  out  8*NREGS  register k at bits [8k+7:8k]
- irq_n  out  1  ~(F & R1[5]), registered
- int_tick, coll_tick, fifth_tick  in  1  set F, C, 5S respectively
- fifth_num  in  5  sprite number, captured with fifth_tick
- vram_req  out  1  access pending (level)
- vram_we  out  1  1 = write, 0 = read
- vram_addr  out  VADDR_W  access address
- vram_wdata  out  8  write data
- vram_ack  in  1  one-cycle completion; vram_rdata valid same cycle
- vram_rdata  in  8  read data

## Operation
- Byte state: 0 = expect first byte, 1 = expect second byte. ctl_wr_tick toggles it; ctl_rd_tick forces it to 0 (wins over a simultaneous write).
- First byte (state 0): latch into w0 and load vram_addr[7:0] immediately.
- Second byte (state 1), din[7]=1: regs[din[REG_AW-1:0]] <= w0; the pointer is untouched.
- Second byte, din[7]=0: vram_addr[13:8] <= din[5:0]. If din[6]=0 (read mode), issue a read at the new address.
- VADDR_W>14: the upper bits form a high counter, loaded from R14 whenever R14 is written by any path.
- Data write: issue a write of din at vram_addr, copy din into the buffer, then increment the pointer.
- Data read: data_dout presents the old buffer during the tick. The pointer then increments and a read is issued at the new address.
- The pointer increments modulo 2**VADDR_W. A carry out of bit 13 increments the high counter. R14 is not updated by the carry.
- VRAM access: issuing sets vram_req=1 and drives we/addr/wdata for that access. Outputs hold until vram_ack. On ack of a read, buffer <= vram_rdata. vram_req drops the cycle after the ack.
- A new access issued while busy re-aims the pending request, so the most recent access wins. If a tick and an ack land in the same cycle, the tick wins: req stays 1 with the new values and the ack's read data is discarded.
- Status flags F, C and 5S are sticky. fifth_num is captured only when 5S=0.
- ctl_rd_tick clears F, C and 5S after the read. A set event in the same cycle as the read wins: the flag stays 1, and the read returns the pre-set value.
- Indirect (INDIRECT=1): R17 = {AII, x, RS[5:0]}. ind_wr_tick writes regs[RS] <= din, except RS==17, which is ignored. If AII=0, RS increments, wrapping 63->0.

## Timing
- Reset (reset_n=0 at a clk edge): all regs 0, w0 0, state 0, flags and fifth_num 0, buffer 0, pointer and high counter 0, vram_req 0, vram_we 0, vram_wdata 0, irq_n 1.
- Register writes are visible on regs_flat on the cycle after the tick. irq_n follows the F/R1[5] change one cycle later.
- vram_req rises the cycle after the issuing tick. Minimum read-ahead latency is tick + 1 + arbiter wait. Asserting ack combinationally in the first req cycle is legal.
- Reset asserted with an access pending abandons the access: req drops at that edge, and any later ack is ignored.

## Test plan
- Reset, ctl writes 0x5A then 0x87 -> R7=0x5A, state back to 0, pointer low byte=0x5A, vram_req stays 0.
- Address 0x3FFF write mode (0xFF, 0x7F), two data writes 0x11, 0x22 -> writes at 0x3FFF then 0x0000, buffer=0x22; with VADDR_W=17, R14=3, the second write goes to 0x10000.
- Read setup 0x00, 0x01 at 0x0100, ack rdata 0xAB -> data_dout=0xAB; dat_rd_tick returns 0xAB and a read is issued at 0x0101.
- int_tick with R1[5]=1 -> irq_n=0 two cycles later; ctl_rd_tick returns 0x80 and clears F, irq_n=1; int_tick coincident with the read -> F stays 1.
- One ctl write 0x12 then ctl_rd_tick -> state=0, so the next write is treated as a first byte; no register changes.
- INDIRECT=1, R17=0x10, three ind writes 0xA0,0xA1,0xA2 -> R16=0xA0, R17 unchanged (write ignored), R18=0xA2, RS=19; with AII=1 all three writes go to R16.

Source files
------------

// File: rtl/vdp_ctl_port_if.sv
// VRAM access bus between the VDP control port and the VRAM arbiter.
// master drives req/we/addr/wdata; slave returns a one-cycle ack with rdata.
interface vdp_ctl_port_if #(
    parameter int VADDR_W = 14
) ();
    logic               vram_req;
    logic               vram_we;
    logic [VADDR_W-1:0] vram_addr;
    logic [7:0]         vram_wdata;
    logic               vram_ack;
    logic [7:0]         vram_rdata;

    modport master (
        output vram_req, vram_we, vram_addr, vram_wdata,
        input  vram_ack, vram_rdata
    );

    modport slave (
        input  vram_req, vram_we, vram_addr, vram_wdata,
        output vram_ack, vram_rdata
    );
endinterface

// File: rtl/vdp_ctl_port.sv
// VDP control/data port: two-byte control decode, register file, status
// flags with IRQ, VRAM pointer with read-ahead buffer and access handshake.
// Ports: clk, reset_n (sync, active-low), ctl/dat/ind write and read ticks,
// din, status_dout, data_dout, regs_flat, irq_n, int/coll/fifth ticks,
// fifth_num, and the VRAM bus through the vram interface (master side).
module vdp_ctl_port #(
    parameter int REG_AW   = 3,
    parameter int VADDR_W  = 14,
    parameter int INDIRECT = 0,
    localparam int NREGS   = 2 ** REG_AW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ctl_wr_tick,
    input  logic                 ctl_rd_tick,
    input  logic                 dat_wr_tick,
    input  logic                 dat_rd_tick,
    input  logic                 ind_wr_tick,
    input  logic [7:0]           din,
    output logic [7:0]           status_dout,
    output logic [7:0]           data_dout,
    output logic [8*NREGS-1:0]   regs_flat,
    output logic                 irq_n,
    input  logic                 int_tick,
    input  logic                 coll_tick,
    input  logic                 fifth_tick,
    input  logic [4:0]           fifth_num,
    vdp_ctl_port_if.master       vram
);
    // Index of the indirect-port control register; only meaningful when
    // INDIRECT=1 (REG_AW=6), folded into range otherwise.
    localparam int I17 = 17 % NREGS;

    logic               byte_st;
    logic [7:0]         w0;
    logic [7:0]         regs [NREGS];
    logic               f_q;
    logic               c_q;
    logic               s5_q;
    logic [4:0]         fnum_q;
    logic [7:0]         buf_q;
    logic [VADDR_W-1:0] ptr_q;
    logic               req_q;
    logic               we_q;
    logic [VADDR_W-1:0] addr_q;
    logic [7:0]         wdata_q;

    logic               ctl_first;
    logic               ctl_reg;
    logic               ctl_addr;
    logic [REG_AW-1:0]  ctl_idx;
    logic               ind_on;
    logic               ind_we;
    logic [5:0]         rs;
    logic               aii;
    logic               ind_hi;
    logic               ctl_hi;
    logic               hi_ld;
    logic [VADDR_W-1:0] ptr_pre;
    logic [VADDR_W-1:0] ptr_n;
    logic               iss;
    logic               iss_we;
    logic [VADDR_W-1:0] iss_addr;

    assign ctl_first = ctl_wr_tick & ~byte_st;
    assign ctl_reg   = ctl_wr_tick & byte_st & din[7];
    assign ctl_addr  = ctl_wr_tick & byte_st & ~din[7];
    assign ctl_idx   = din[REG_AW-1:0];

    assign rs     = regs[I17][5:0];
    assign aii    = regs[I17][7];
    assign ind_on = (INDIRECT != 0) & ind_wr_tick;
    assign ind_we = ind_on & (rs != 6'd17);

    // Any write to R14 reloads the high address counter.
    assign ind_hi = ind_we & (rs == 6'd14);
    assign ctl_hi = ctl_reg & (int'(ctl_idx) == 14);
    assign hi_ld  = ind_hi | ctl_hi;

    always_comb begin
        ptr_pre = ptr_q;
        if (ctl_first)
            ptr_pre[7:0] = din;
        if (ctl_addr)
            ptr_pre[13:8] = din[5:0];
        ptr_n = ptr_pre;
        if (dat_wr_tick || dat_rd_tick)
            ptr_n = ptr_pre + VADDR_W'(1);
        if (hi_ld)
            for (int b = 14; b < VADDR_W; b++)
                ptr_n[b] = ind_hi ? din[b-14] : w0[b-14];
    end

    // Writes go to the pre-increment address; reads target the new one.
    always_comb begin
        iss      = 1'b0;
        iss_we   = 1'b0;
        iss_addr = ptr_n;
        if (dat_wr_tick) begin
            iss      = 1'b1;
            iss_we   = 1'b1;
            iss_addr = ptr_pre;
        end else if (dat_rd_tick || (ctl_addr && !din[6])) begin
            iss = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            byte_st <= 1'b0;
            w0      <= '0;
            for (int k = 0; k < NREGS; k++)
                regs[k] <= '0;
            f_q     <= 1'b0;
            c_q     <= 1'b0;
            s5_q    <= 1'b0;
            fnum_q  <= '0;
            buf_q   <= '0;
            ptr_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            irq_n   <= 1'b1;
        end else begin
            if (ctl_rd_tick)
                byte_st <= 1'b0;
            else if (ctl_wr_tick)
                byte_st <= ~byte_st;
            if (ctl_first)
                w0 <= din;

            // Later assignments win: a direct write to R17 beats its
            // auto-increment.
            if (ind_on && !aii)
                regs[I17][5:0] <= rs + 6'd1;
            if (ctl_reg)
                regs[ctl_idx] <= w0;
            if (ind_we)
                regs[rs[REG_AW-1:0]] <= din;

            f_q  <= (f_q & ~ctl_rd_tick) | int_tick;
            c_q  <= (c_q & ~ctl_rd_tick) | coll_tick;
            s5_q <= (s5_q & ~ctl_rd_tick) | fifth_tick;
            if (fifth_tick && !s5_q)
                fnum_q <= fifth_num;
            irq_n <= ~(f_q & regs[1][5]);

            ptr_q <= ptr_n;

            // A new tick re-aims the pending access and drops any
            // read data acked in the same cycle.
            if (dat_wr_tick)
                buf_q <= din;
            else if (req_q && vram.vram_ack && !we_q && !iss)
                buf_q <= vram.vram_rdata;

            if (iss) begin
                req_q  <= 1'b1;
                we_q   <= iss_we;
                addr_q <= iss_addr;
                if (iss_we)
                    wdata_q <= din;
            end else if (vram.vram_ack) begin
                req_q <= 1'b0;
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < NREGS; k++)
            regs_flat[8*k +: 8] = regs[k];
    end

    assign status_dout     = {f_q, s5_q, c_q, fnum_q};
    assign data_dout       = buf_q;
    assign vram.vram_req   = req_q;
    assign vram.vram_we    = we_q;
    assign vram.vram_addr  = addr_q;
    assign vram.vram_wdata = wdata_q;
endmodule

// File: tb/tb_vdp_ctl_port.sv
// Scoreboard bench for vdp_ctl_port: two instances (base 8-reg/14-bit and
// 64-reg/17-bit with indirect port), expected accesses/reads queued.
module tb_vdp_ctl_port;
    typedef struct packed {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wd;
    } acc_t;

    localparam int K_CW  = 0;
    localparam int K_CR  = 1;
    localparam int K_DW  = 2;
    localparam int K_DR  = 3;
    localparam int K_IW  = 4;
    localparam int K_INT = 5;
    localparam int K_5S  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       ctl_wr [2];
    logic       ctl_rd [2];
    logic       dat_wr [2];
    logic       dat_rd [2];
    logic       ind_wr [2];
    logic       int_t  [2];
    logic       coll_t [2];
    logic       fifth_t[2];
    logic [7:0] din    [2];
    logic [4:0] fnum   [2];
    logic [7:0] sdout  [2];
    logic [7:0] ddout  [2];
    logic       irqn   [2];
    logic [63:0]  regsA;
    logic [511:0] regsB;

    vdp_ctl_port_if #(.VADDR_W(14)) vifA ();
    vdp_ctl_port_if #(.VADDR_W(17)) vifB ();

    vdp_ctl_port dutA (
        .clk(clk), .reset_n(reset_n),
        .ctl_wr_tick(ctl_wr[0]), .ctl_rd_tick(ctl_rd[0]),
        .dat_wr_tick(dat_wr[0]), .dat_rd_tick(dat_rd[0]),
        .ind_wr_tick(ind_wr[0]), .din(din[0]),
        .status_dout(sdout[0]), .data_dout(ddout[0]),
        .regs_flat(regsA), .irq_n(irqn[0]),
        .int_tick(int_t[0]), .coll_tick(coll_t[0]),
        .fifth_tick(fifth_t[0]), .fifth_num(fnum[0]),
        .vram(vifA)
    );

    vdp_ctl_port #(.REG_AW(6), .VADDR_W(17), .INDIRECT(1)) dutB (
        .clk(clk), .reset_n(reset_n),
        .ctl_wr_tick(ctl_wr[1]), .ctl_rd_tick(ctl_rd[1]),
        .dat_wr_tick(dat_wr[1]), .dat_rd_tick(dat_rd[1]),
        .ind_wr_tick(ind_wr[1]), .din(din[1]),
        .status_dout(sdout[1]), .data_dout(ddout[1]),
        .regs_flat(regsB), .irq_n(irqn[1]),
        .int_tick(int_t[1]), .coll_tick(coll_t[1]),
        .fifth_tick(fifth_t[1]), .fifth_num(fnum[1]),
        .vram(vifB)
    );

    int passed = 0;
    int total  = 0;

    acc_t       accqA[$];
    acc_t       accqB[$];
    logic [7:0] rdqA[$];
    logic [7:0] rdqB[$];
    logic [7:0] stqA[$];
    logic [7:0] stqB[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_acc(string nm, acc_t act, acc_t exp);
        if (!exp.we) begin
            act.wd = '0;
            exp.wd = '0;
        end
        chk(nm, 32'(act), 32'(exp));
    endtask

    task automatic miss(string nm);
        total++;
        $display("FAIL %s: got output expected none queued", nm);
    endtask

    // Monitor: compares each newly presented access and each read tick.
    acc_t curA, curB, pcurA, pcurB;
    logic preqA, preqB, packA, packB;
    assign curA = {vifA.vram_we, 3'b000, vifA.vram_addr, vifA.vram_wdata};
    assign curB = {vifB.vram_we, vifB.vram_addr, vifB.vram_wdata};

    always @(negedge clk) begin
        if (reset_n) begin
            if (vifA.vram_req && (!preqA || packA || curA != pcurA)) begin
                if (accqA.size() == 0) miss("accA");
                else chk_acc("accA", curA, accqA.pop_front());
            end
            if (vifB.vram_req && (!preqB || packB || curB != pcurB)) begin
                if (accqB.size() == 0) miss("accB");
                else chk_acc("accB", curB, accqB.pop_front());
            end
            if (dat_rd[0]) begin
                if (rdqA.size() == 0) miss("rdA");
                else chk("rdA", 32'(ddout[0]), 32'(rdqA.pop_front()));
            end
            if (dat_rd[1]) begin
                if (rdqB.size() == 0) miss("rdB");
                else chk("rdB", 32'(ddout[1]), 32'(rdqB.pop_front()));
            end
            if (ctl_rd[0]) begin
                if (stqA.size() == 0) miss("stA");
                else chk("stA", 32'(sdout[0]), 32'(stqA.pop_front()));
            end
            if (ctl_rd[1]) begin
                if (stqB.size() == 0) miss("stB");
                else chk("stB", 32'(sdout[1]), 32'(stqB.pop_front()));
            end
        end
        preqA <= vifA.vram_req;
        preqB <= vifB.vram_req;
        packA <= vifA.vram_ack;
        packB <= vifB.vram_ack;
        pcurA <= curA;
        pcurB <= curB;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(int d);
        ctl_wr[d]  = 1'b0;
        ctl_rd[d]  = 1'b0;
        dat_wr[d]  = 1'b0;
        dat_rd[d]  = 1'b0;
        ind_wr[d]  = 1'b0;
        int_t[d]   = 1'b0;
        coll_t[d]  = 1'b0;
        fifth_t[d] = 1'b0;
    endtask

    task automatic pulse(int d, int k, logic [7:0] v);
        din[d] = v;
        case (k)
            K_CW:    ctl_wr[d]  = 1'b1;
            K_CR:    ctl_rd[d]  = 1'b1;
            K_DW:    dat_wr[d]  = 1'b1;
            K_DR:    dat_rd[d]  = 1'b1;
            K_IW:    ind_wr[d]  = 1'b1;
            K_INT:   int_t[d]   = 1'b1;
            default: fifth_t[d] = 1'b1;
        endcase
        cyc();
        clr(d);
    endtask

    task automatic set_ack(int d, logic a, logic [7:0] rd);
        if (d == 0) begin
            vifA.vram_ack   = a;
            vifA.vram_rdata = rd;
        end else begin
            vifB.vram_ack   = a;
            vifB.vram_rdata = rd;
        end
    endtask

    task automatic ack(int d, logic [7:0] rd);
        set_ack(d, 1'b1, rd);
        cyc();
        set_ack(d, 1'b0, 8'h00);
    endtask

    task automatic exp_acc(int d, logic we, logic [16:0] a, logic [7:0] w);
        if (d == 0) accqA.push_back({we, a, w});
        else accqB.push_back({we, a, w});
    endtask

    function automatic logic [7:0] rA(int k);
        return regsA[8*k +: 8];
    endfunction

    function automatic logic [7:0] rB(int k);
        return regsB[8*k +: 8];
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            clr(d);
            din[d]  = 8'h00;
            fnum[d] = 5'h00;
        end
        set_ack(0, 1'b0, 8'h00);
        set_ack(1, 1'b0, 8'h00);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        chk("rst statA", 32'(sdout[0]), 32'h00);
        chk("rst dataA", 32'(ddout[0]), 32'h00);
        chk("rst irqA", 32'(irqn[0]), 32'h1);
        chk("rst reqA", 32'(vifA.vram_req), 32'h0);
        chk("rst weA", 32'(vifA.vram_we), 32'h0);
        chk("rst regsA0", regsA[31:0], 32'h0);
        chk("rst regsA1", regsA[63:32], 32'h0);
        chk("rst reqB", 32'(vifB.vram_req), 32'h0);
        chk("rst irqB", 32'(irqn[1]), 32'h1);

        // Register write: R7 <= 0x5A
        pulse(0, K_CW, 8'h5A);
        pulse(0, K_CW, 8'h87);
        chk("R7", 32'(rA(7)), 32'h5A);
        chk("no req", 32'(vifA.vram_req), 32'h0);
        exp_acc(0, 1'b1, 17'h0005A, 8'h33);
        pulse(0, K_DW, 8'h33);
        ack(0, 8'h00);
        pulse(0, K_CW, 8'h20);
        pulse(0, K_CW, 8'h81);
        chk("R1", 32'(rA(1)), 32'h20);

        // Write mode at 0x3FFF, wraps to 0x0000
        pulse(0, K_CW, 8'hFF);
        pulse(0, K_CW, 8'h7F);
        exp_acc(0, 1'b1, 17'h03FFF, 8'h11);
        pulse(0, K_DW, 8'h11);
        ack(0, 8'h00);
        exp_acc(0, 1'b1, 17'h00000, 8'h22);
        pulse(0, K_DW, 8'h22);
        ack(0, 8'h00);
        chk("buf wr", 32'(ddout[0]), 32'h22);

        // Read-ahead at 0x0100
        pulse(0, K_CW, 8'h00);
        exp_acc(0, 1'b0, 17'h00100, 8'h00);
        pulse(0, K_CW, 8'h01);
        ack(0, 8'hAB);
        chk("buf AB", 32'(ddout[0]), 32'hAB);
        rdqA.push_back(8'hAB);
        exp_acc(0, 1'b0, 17'h00101, 8'h00);
        pulse(0, K_DR, 8'h00);
        ack(0, 8'hCD);
        chk("buf CD", 32'(ddout[0]), 32'hCD);

        // Tick and ack together: tick wins, ack data dropped
        pulse(0, K_CW, 8'h00);
        exp_acc(0, 1'b0, 17'h00200, 8'h00);
        pulse(0, K_CW, 8'h02);
        rdqA.push_back(8'hCD);
        exp_acc(0, 1'b0, 17'h00201, 8'h00);
        set_ack(0, 1'b1, 8'hEE);
        dat_rd[0] = 1'b1;
        cyc();
        clr(0);
        set_ack(0, 1'b0, 8'h00);
        chk("ack dropped", 32'(ddout[0]), 32'hCD);
        chk("req held", 32'(vifA.vram_req), 32'h1);
        ack(0, 8'h5F);
        chk("buf 5F", 32'(ddout[0]), 32'h5F);
        cyc();
        chk("req drop", 32'(vifA.vram_req), 32'h0);

        // Interrupt flag and irq_n
        pulse(0, K_INT, 8'h00);
        chk("irq lag", 32'(irqn[0]), 32'h1);
        cyc();
        chk("irq low", 32'(irqn[0]), 32'h0);
        stqA.push_back(8'h80);
        pulse(0, K_CR, 8'h00);
        chk("F clr", 32'(sdout[0]), 32'h00);
        cyc();
        chk("irq high", 32'(irqn[0]), 32'h1);
        stqA.push_back(8'h00);
        int_t[0]  = 1'b1;
        ctl_rd[0] = 1'b1;
        cyc();
        clr(0);
        chk("F sticky", 32'(sdout[0]), 32'h80);
        stqA.push_back(8'h80);
        pulse(0, K_CR, 8'h00);

        // Collision / fifth sprite capture
        fnum[0]    = 5'h0B;
        coll_t[0]  = 1'b1;
        fifth_t[0] = 1'b1;
        cyc();
        clr(0);
        chk("C 5S", 32'(sdout[0]), 32'h6B);
        fnum[0] = 5'h1F;
        pulse(0, K_5S, 8'h00);
        chk("fnum hold", 32'(sdout[0]), 32'h6B);
        stqA.push_back(8'h6B);
        pulse(0, K_CR, 8'h00);
        chk("flags clr", 32'(sdout[0]), 32'h0B);

        // Status read resets byte state
        pulse(0, K_CW, 8'h12);
        stqA.push_back(8'h0B);
        pulse(0, K_CR, 8'h00);
        pulse(0, K_CW, 8'h34);
        pulse(0, K_CW, 8'h83);
        chk("R3", 32'(rA(3)), 32'h34);
        chk("R2", 32'(rA(2)), 32'h00);

        // Indirect port disabled on base instance
        pulse(0, K_IW, 8'h99);
        chk("noind R0", 32'(rA(0)), 32'h00);
        chk("noind R1", 32'(rA(1)), 32'h20);

        // Wide address: R14 high counter
        pulse(1, K_CW, 8'h03);
        pulse(1, K_CW, 8'h8E);
        chk("B R14", 32'(rB(14)), 32'h03);
        pulse(1, K_CW, 8'hFF);
        pulse(1, K_CW, 8'h7F);
        exp_acc(1, 1'b1, 17'h0FFFF, 8'h11);
        pulse(1, K_DW, 8'h11);
        ack(1, 8'h00);
        exp_acc(1, 1'b1, 17'h10000, 8'h22);
        pulse(1, K_DW, 8'h22);
        ack(1, 8'h00);
        chk("R14 no carry", 32'(rB(14)), 32'h03);

        // Indirect writes with auto-increment
        pulse(1, K_CW, 8'h10);
        pulse(1, K_CW, 8'h91);
        pulse(1, K_IW, 8'hA0);
        pulse(1, K_IW, 8'hA1);
        pulse(1, K_IW, 8'hA2);
        chk("R16", 32'(rB(16)), 32'hA0);
        chk("R17 RS", 32'(rB(17)), 32'h13);
        chk("R18", 32'(rB(18)), 32'hA2);
        pulse(1, K_CW, 8'h90);
        pulse(1, K_CW, 8'h91);
        pulse(1, K_IW, 8'hB0);
        pulse(1, K_IW, 8'hB1);
        pulse(1, K_IW, 8'hB2);
        chk("AII R16", 32'(rB(16)), 32'hB2);
        chk("AII R17", 32'(rB(17)), 32'h90);

        // R14 via indirect path reloads high counter
        pulse(1, K_CW, 8'h0E);
        pulse(1, K_CW, 8'h91);
        pulse(1, K_IW, 8'h01);
        chk("ind R14", 32'(rB(14)), 32'h01);
        chk("ind R17", 32'(rB(17)), 32'h0F);
        pulse(1, K_CW, 8'h00);
        pulse(1, K_CW, 8'h40);
        exp_acc(1, 1'b1, 17'h04000, 8'h55);
        pulse(1, K_DW, 8'h55);
        ack(1, 8'h00);

        // RS wraps 63 -> 0
        pulse(1, K_CW, 8'h3F);
        pulse(1, K_CW, 8'h91);
        pulse(1, K_IW, 8'h77);
        chk("R63", 32'(rB(63)), 32'h77);
        chk("RS wrap", 32'(rB(17)), 32'h00);

        // Reset abandons a pending access
        pulse(0, K_CW, 8'h00);
        exp_acc(0, 1'b0, 17'h00000, 8'h00);
        pulse(0, K_CW, 8'h00);
        cyc();
        reset_n = 1'b0;
        cyc();
        chk("rst abandon", 32'(vifA.vram_req), 32'h0);
        reset_n = 1'b1;
        ack(0, 8'h77);
        chk("late ack", 32'(ddout[0]), 32'h00);
        chk("late req", 32'(vifA.vram_req), 32'h0);
        chk("rst R7", 32'(rA(7)), 32'h00);
        chk("rst R63", 32'(rB(63)), 32'h00);

        repeat (3) cyc();
        chk("accqA left", 32'(accqA.size()), 32'h0);
        chk("accqB left", 32'(accqB.size()), 32'h0);
        chk("rdq left", 32'(rdqA.size() + rdqB.size()), 32'h0);
        chk("stq left", 32'(stqA.size() + stqB.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
